// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the instruction-fetch sequencer and the debug unit:
// state encodings (visible on the o_state debug port) and the command bytes
// accepted over the debug UART.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
   localparam logic [7:0] CMD_CONT  = 8'h43;  // 'C'
   localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
   localparam logic [7:0] CMD_NEXT  = 8'h4E;  // 'N'
   localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'

   // True when a received byte is present this cycle and equals the command.
   function automatic logic is_cmd(input logic vld, input logic [7:0] rx_byte,
                                   input logic [7:0] cmd);
      return vld && (rx_byte == cmd);
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the sequencer's bus signals: UART RX byte stream, the instruction
// seen by the fetch stage, PC control, instruction-memory write port and the
// debug/status outputs.
//   master : the sequencer (drives o_*, samples i_*)
//   slave  : the environment (UART, fetch stage, memory, debug unit)
// -----------------------------------------------------------------------------
interface fetch_sequencer_if
   import fetch_sequencer_pkg::*;
#(
   parameter int LEN    = 32,
   parameter int ADDR_W = 11
);
   logic [7:0]         i_rx_data;
   logic               i_rx_valid;
   logic [LEN-1:0]     i_instruccion;
   logic               o_pc_enable;
   logic               o_pc_flush;
   logic               o_imem_we;
   logic [ADDR_W-1:0]  o_imem_addr;
   logic [LEN-1:0]     o_imem_data;
   logic [STATE_W-1:0] o_state;
   logic               o_load_ovf;
   logic [LEN-1:0]     o_cycle_count;

   modport master (
      input  i_rx_data, i_rx_valid, i_instruccion,
      output o_pc_enable, o_pc_flush, o_imem_we, o_imem_addr, o_imem_data,
             o_state, o_load_ovf, o_cycle_count
   );

   modport slave (
      output i_rx_data, i_rx_valid, i_instruccion,
      input  o_pc_enable, o_pc_flush, o_imem_we, o_imem_addr, o_imem_data,
             o_state, o_load_ovf, o_cycle_count
   );
endinterface

// File: rtl/fetch_sequencer_word_assembler.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_word_assembler
// Packs a byte stream MSB-first into LEN-bit words.
//   i_clk, i_rst   : clock, async active-high reset
//   i_clear        : restart packing at byte 0 (start of a load)
//   i_byte/i_valid : incoming byte and its strobe
//   o_word         : word being assembled (complete while o_word_valid=1)
//   o_word_valid   : one-cycle pulse, the cycle after the last byte's strobe
// -----------------------------------------------------------------------------
module fetch_sequencer_word_assembler #(
   parameter int LEN = 32
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_clear,
   input  logic [7:0]     i_byte,
   input  logic           i_valid,
   output logic [LEN-1:0] o_word,
   output logic           o_word_valid
);
   localparam int BYTES = LEN / 8;
   localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

   logic [BC_W-1:0] byte_ctr;
   logic [LEN-1:0]  shift_reg;
   logic            word_valid;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         byte_ctr   <= '0;
         shift_reg  <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (i_clear) begin
            byte_ctr <= '0;
         end else if (i_valid) begin
            // Earlier bytes move toward the MSB end, so the first byte ends up on top.
            shift_reg <= (shift_reg << 8) | LEN'(i_byte);
            if (byte_ctr == LAST_BYTE) begin
               byte_ctr   <= '0;
               word_valid <= 1'b1;
            end else begin
               byte_ctr <= byte_ctr + 1'b1;
            end
         end
      end
   end

   assign o_word       = shift_reg;
   assign o_word_valid = word_valid;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller. Loads instruction memory from the debug UART
// byte stream, then runs the fetch stage continuously ('C') or one instruction
// per 'N' in step mode ('S'). Stops on HALT_WORD; 'R' in DONE flushes the PC.
//   i_clk, i_rst        : clock, async active-high reset
//   bus.i_rx_data/valid : received UART byte and strobe
//   bus.i_instruccion   : instruction currently presented by the fetch stage
//   bus.o_pc_enable     : PC may advance this cycle
//   bus.o_pc_flush      : one-cycle pulse, PC back to 0
//   bus.o_imem_we/addr/data : instruction-memory write port
//   bus.o_state         : current FSM state (debug)
//   bus.o_load_ovf      : sticky, a load word was dropped because memory was full
//   bus.o_cycle_count   : cycles with o_pc_enable=1 since the last flush
// -----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int             LEN       = 32,
   parameter int             ADDR_W    = 11,
   parameter logic [LEN-1:0] HALT_WORD = {LEN{1'b1}}
) (
   input logic               i_clk,
   input logic               i_rst,
   fetch_sequencer_if.master bus
);
   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

   state_t             state, state_nx;
   logic [ADDR_W-1:0]  addr_ctr;
   logic               addr_full;
   logic               load_ovf;
   logic               step_flag;
   logic [LEN-1:0]     cycle_cnt;

   logic [LEN-1:0]     word;
   logic               word_valid;
   logic               asm_clear, asm_valid;
   logic               pc_enable, pc_flush, imem_we;
   logic               load_start, ovf_set, step_set, step_clr;
   logic               instr_halt, word_halt;

   fetch_sequencer_word_assembler #(.LEN(LEN)) u_asm (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clear      (asm_clear),
      .i_byte       (bus.i_rx_data),
      .i_valid      (asm_valid),
      .o_word       (word),
      .o_word_valid (word_valid)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      pc_enable  = 1'b0;
      pc_flush   = 1'b0;
      imem_we    = 1'b0;
      asm_clear  = 1'b0;
      asm_valid  = 1'b0;
      load_start = 1'b0;
      ovf_set    = 1'b0;
      step_set   = 1'b0;
      step_clr   = 1'b0;
      instr_halt = (bus.i_instruccion == HALT_WORD);
      word_halt  = (word == HALT_WORD);
      case (state)
         ST_IDLE: begin
            if (is_cmd(bus.i_rx_valid, bus.i_rx_data, CMD_LOAD)) begin
               state_nx   = ST_LOAD;
               asm_clear  = 1'b1;
               load_start = 1'b1;
            end else if (is_cmd(bus.i_rx_valid, bus.i_rx_data, CMD_CONT)) begin
               state_nx = ST_RUN;
            end else if (is_cmd(bus.i_rx_valid, bus.i_rx_data, CMD_STEP)) begin
               state_nx = ST_STEP;
            end
         end
         ST_LOAD: begin
            // A byte arriving alongside the final HALT write belongs to the next
            // command, not to a new word.
            asm_valid = bus.i_rx_valid && !(word_valid && word_halt);
            if (word_valid) begin
               if (addr_full) ovf_set = 1'b1;
               else           imem_we = 1'b1;
               if (word_halt) state_nx = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (instr_halt) state_nx  = ST_DONE;
            else            pc_enable = 1'b1;
         end
         ST_STEP: begin
            if (step_flag) begin
               step_clr = 1'b1;
               if (instr_halt) state_nx  = ST_DONE;
               else            pc_enable = 1'b1;
            end else if (is_cmd(bus.i_rx_valid, bus.i_rx_data, CMD_NEXT)) begin
               step_set = 1'b1;
            end
         end
         ST_DONE: begin
            if (is_cmd(bus.i_rx_valid, bus.i_rx_data, CMD_RESET)) begin
               pc_flush = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         addr_ctr  <= '0;
         addr_full <= 1'b0;
         load_ovf  <= 1'b0;
         step_flag <= 1'b0;
         cycle_cnt <= '0;
      end else begin
         if (load_start) begin
            addr_ctr  <= '0;
            addr_full <= 1'b0;
         end else if (imem_we) begin
            // The last slot saturates the counter instead of wrapping onto word 0.
            if (addr_ctr == ADDR_MAX) addr_full <= 1'b1;
            else                      addr_ctr  <= addr_ctr + 1'b1;
         end
         if (ovf_set) load_ovf <= 1'b1;
         if (step_clr)      step_flag <= 1'b0;
         else if (step_set) step_flag <= 1'b1;
         if (pc_flush)       cycle_cnt <= '0;
         else if (pc_enable) cycle_cnt <= cycle_cnt + 1'b1;
      end
   end

   assign bus.o_pc_enable   = pc_enable;
   assign bus.o_pc_flush    = pc_flush;
   assign bus.o_imem_we     = imem_we;
   assign bus.o_imem_addr   = addr_ctr;
   assign bus.o_imem_data   = word;
   assign bus.o_state       = state;
   assign bus.o_load_ovf    = load_ovf;
   assign bus.o_cycle_count = cycle_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Bench for fetch_sequencer. Two instances: a full-size one (ADDR_W=11) that is
// given a small instruction memory and PC model acting as the fetch stage, and
// a tiny one (ADDR_W=2) for the memory-full case.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic clk;
   logic rst;

   fetch_sequencer_if #(.LEN(32), .ADDR_W(11)) bus1 ();
   fetch_sequencer_if #(.LEN(32), .ADDR_W(2))  bus2 ();

   fetch_sequencer #(.LEN(32), .ADDR_W(11), .HALT_WORD(HALT)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus1.master)
   );

   fetch_sequencer #(.LEN(32), .ADDR_W(2), .HALT_WORD(HALT)) dut2 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus2.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Fetch-stage model: memory filled by the DUT's write port, PC stepped by
   // o_pc_enable and zeroed by o_pc_flush.
   logic [31:0] tb_mem [0:2047];
   logic [10:0] pc = '0;
   logic        s_en = 1'b0, s_we = 1'b0, s_fl = 1'b0;
   logic [10:0] s_addr = '0;
   logic [31:0] s_data = '0;

   int en_cnt = 0, fl_cnt = 0, wr_cnt = 0;
   int w2_cnt = 0;
   logic [1:0] w2a [0:7];

   assign bus1.i_instruccion = tb_mem[pc];
   assign bus2.i_instruccion = 32'h0;

   always @(negedge clk) begin
      s_en   = bus1.o_pc_enable;
      s_fl   = bus1.o_pc_flush;
      s_we   = bus1.o_imem_we;
      s_addr = bus1.o_imem_addr;
      s_data = bus1.o_imem_data;
      if (s_en) en_cnt++;
      if (s_fl) fl_cnt++;
      if (s_we) wr_cnt++;
      if (bus2.o_imem_we) begin
         if (w2_cnt < 8) w2a[w2_cnt] = bus2.o_imem_addr;
         w2_cnt++;
      end
   end

   always @(posedge clk) begin
      if (s_we) tb_mem[s_addr] <= s_data;
      if (rst || s_fl) pc <= '0;
      else if (s_en)   pc <= pc + 11'd1;
   end

   int n_vec = 0;
   int n_miss = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Called at posedge+1; holds the byte for exactly one cycle.
   task automatic send(input logic [7:0] b, input bit to2);
      if (to2) begin
         bus2.i_rx_valid = 1'b1;
         bus2.i_rx_data  = b;
      end else begin
         bus1.i_rx_valid = 1'b1;
         bus1.i_rx_data  = b;
      end
      @(posedge clk);
      #1;
      bus1.i_rx_valid = 1'b0;
      bus2.i_rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit to2);
      for (int k = 3; k >= 0; k--) send(w[k*8 +: 8], to2);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input string nm);
      for (int k = 0; k < 50 && bus1.o_state != 3'd4; k++) idle(1);
      chk(nm, 32'(bus1.o_state), 32'd4);
   endtask

   typedef struct {
      logic        vld;
      logic [7:0]  data;
      logic [2:0]  st;
      logic        we;
      logic [10:0] addr;
      logic [31:0] wdata;
   } vec_t;

   vec_t tbl [0:10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, e0, f0;
      logic mis;

      tbl[0]  = '{1'b1, 8'h4C, 3'd0, 1'b0, 11'd0, 32'h0};
      tbl[1]  = '{1'b1, 8'h12, 3'd1, 1'b0, 11'd0, 32'h0};
      tbl[2]  = '{1'b1, 8'h34, 3'd1, 1'b0, 11'd0, 32'h0};
      tbl[3]  = '{1'b1, 8'h56, 3'd1, 1'b0, 11'd0, 32'h0};
      tbl[4]  = '{1'b1, 8'h78, 3'd1, 1'b0, 11'd0, 32'h0};
      tbl[5]  = '{1'b1, 8'hFF, 3'd1, 1'b1, 11'd0, 32'h1234_5678};
      tbl[6]  = '{1'b1, 8'hFF, 3'd1, 1'b0, 11'd0, 32'h0};
      tbl[7]  = '{1'b1, 8'hFF, 3'd1, 1'b0, 11'd0, 32'h0};
      tbl[8]  = '{1'b1, 8'hFF, 3'd1, 1'b0, 11'd0, 32'h0};
      tbl[9]  = '{1'b0, 8'h00, 3'd1, 1'b1, 11'd1, 32'hFFFF_FFFF};
      tbl[10] = '{1'b0, 8'h00, 3'd0, 1'b0, 11'd0, 32'h0};

      rst = 1'b1;
      bus1.i_rx_valid = 1'b0;
      bus1.i_rx_data  = 8'h00;
      bus2.i_rx_valid = 1'b0;
      bus2.i_rx_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk("rst_state", 32'(bus1.o_state), 32'd0);
      chk("rst_we", 32'(bus1.o_imem_we), 32'd0);
      chk("rst_en", 32'(bus1.o_pc_enable), 32'd0);
      chk("rst_flush", 32'(bus1.o_pc_flush), 32'd0);
      chk("rst_addr", 32'(bus1.o_imem_addr), 32'd0);
      chk("rst_data", bus1.o_imem_data, 32'd0);
      chk("rst_ovf", 32'(bus1.o_load_ovf), 32'd0);
      chk("rst_count", bus1.o_cycle_count, 32'd0);
      chk("rst_ovf2", 32'(bus2.o_load_ovf), 32'd0);
      rst = 1'b0;

      // T1: reset mid-LOAD after two bytes
      send(8'h4C, 1'b0);
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      w0 = wr_cnt;
      rst = 1'b1;
      #1;
      chk("t1_state", 32'(bus1.o_state), 32'd0);
      chk("t1_data", bus1.o_imem_data, 32'd0);
      chk("t1_we", 32'(bus1.o_imem_we), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(3);
      chk("t1_no_write", 32'(wr_cnt - w0), 32'd0);
      chk("t1_idle", 32'(bus1.o_state), 32'd0);

      // T2: back-to-back load, one table row per cycle
      for (int i = 0; i <= 10; i++) begin
         bus1.i_rx_valid = tbl[i].vld;
         bus1.i_rx_data  = tbl[i].data;
         @(negedge clk);
         mis = (bus1.o_state !== tbl[i].st) || (bus1.o_imem_we !== tbl[i].we) ||
               (bus1.o_pc_enable !== 1'b0) || (bus1.o_pc_flush !== 1'b0) ||
               (tbl[i].we && ((bus1.o_imem_addr !== tbl[i].addr) ||
                              (bus1.o_imem_data !== tbl[i].wdata)));
         n_vec++;
         if (mis) begin
            n_miss++;
            $display("FAIL t2_row%0d: state=%0d we=%0b addr=%0h data=%0h en=%0b fl=%0b, expected state=%0d we=%0b addr=%0h data=%0h en=0 fl=0",
                     i, bus1.o_state, bus1.o_imem_we, bus1.o_imem_addr, bus1.o_imem_data,
                     bus1.o_pc_enable, bus1.o_pc_flush,
                     tbl[i].st, tbl[i].we, tbl[i].addr, tbl[i].wdata);
         end
         @(posedge clk);
         #1;
      end
      bus1.i_rx_valid = 1'b0;

      // Program for T3-T5: three NOPs then HALT
      w0 = wr_cnt;
      send(8'h4C, 1'b0);
      send_word(NOP, 1'b0);
      send_word(NOP, 1'b0);
      send_word(NOP, 1'b0);
      send_word(HALT, 1'b0);
      idle(3);
      chk("prog_writes", 32'(wr_cnt - w0), 32'd4);
      chk("prog_addr", 32'(bus1.o_imem_addr), 32'd4);
      chk("prog_idle", 32'(bus1.o_state), 32'd0);

      // T3: continuous run
      e0 = en_cnt;
      send(8'h43, 1'b0);
      wait_done("t3_done");
      chk("t3_enables", 32'(en_cnt - e0), 32'd3);
      chk("t3_count", bus1.o_cycle_count, 32'd3);

      // T5: flush from DONE, then rerun from address 0
      f0 = fl_cnt;
      send(8'h52, 1'b0);
      chk("t5_flush", 32'(fl_cnt - f0), 32'd1);
      chk("t5_count", bus1.o_cycle_count, 32'd0);
      chk("t5_idle", 32'(bus1.o_state), 32'd0);
      e0 = en_cnt;
      send(8'h43, 1'b0);
      wait_done("t5_done");
      chk("t5_enables", 32'(en_cnt - e0), 32'd3);
      chk("t5_count2", bus1.o_cycle_count, 32'd3);

      // T4: step mode
      send(8'h52, 1'b0);
      e0 = en_cnt;
      send(8'h53, 1'b0);
      idle(3);
      chk("t4_step_state", 32'(bus1.o_state), 32'd3);
      chk("t4_no_free_run", 32'(en_cnt - e0), 32'd0);
      send(8'h4E, 1'b0);
      idle(10);
      send(8'h4E, 1'b0);
      idle(10);
      chk("t4_two_steps", 32'(en_cnt - e0), 32'd2);
      chk("t4_count2", bus1.o_cycle_count, 32'd2);
      send(8'h4E, 1'b0);
      send(8'h4E, 1'b0);
      idle(10);
      chk("t4_b2b_one_step", 32'(en_cnt - e0), 32'd3);
      // Fetch stage now presents HALT: a step request must end in DONE, no enable.
      if (bus1.o_state == 3'd3) send(8'h4E, 1'b0);
      idle(5);
      chk("t4_halt_done", 32'(bus1.o_state), 32'd4);
      chk("t4_halt_no_en", 32'(en_cnt - e0), 32'd3);
      chk("t4_count3", bus1.o_cycle_count, 32'd3);

      // T6: memory full on the ADDR_W=2 instance
      send(8'h4C, 1'b1);
      send_word(32'h1111_1111, 1'b1);
      send_word(32'h2222_2222, 1'b1);
      send_word(32'h3333_3333, 1'b1);
      send_word(32'h4444_4444, 1'b1);
      send_word(32'h5555_5555, 1'b1);
      send_word(HALT, 1'b1);
      idle(3);
      chk("t6_writes", 32'(w2_cnt), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("t6_addr%0d", i), 32'(w2a[i]), 32'(i));
      chk("t6_ovf", 32'(bus2.o_load_ovf), 32'd1);
      chk("t6_no_wrap", 32'(bus2.o_imem_addr), 32'd3);
      chk("t6_idle", 32'(bus2.o_state), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
